// File: rtl/mem_if_pkg.sv
// Shared definitions for the single-port vld/rdy memory interface.
// Holds the default address/data widths used by the pattern master,
// the memory responder and the bench, plus the master's FSM state type.
package mem_if_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RCHK,
    DONE
  } state_e;

endpackage

// File: rtl/mem_pattern_master.sv
// mem_pattern_master: requester-side built-in self-test engine.
// On start it writes pattern seed+k to addresses base+k (k = 0..len-1,
// address and data both wrap), then reads every location back one at a
// time and compares it against the same pattern.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           start request, only looked at in IDLE
//   base_i/len_i/seed_i  first address, location count (0..2^AW), pattern seed
//   busy_o            run in progress (cycle after start through DONE)
//   done_o            one-cycle completion pulse
//   pass_o            last run had zero mismatches
//   err_cnt_o         mismatch count of the last run
//   first_err_addr_o  address of the first mismatch (0 if none)
//   vld_o/wr_o/addr_o/wdata_o  request side of the memory interface
//   rdy_i/rdata_i     responder ready and read data
module mem_pattern_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  vld_o,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  rdy_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] k, k_n;
  logic [ADDR_WIDTH-1:0] base_r, base_n;
  logic [ADDR_WIDTH:0]   len_r, len_n;
  logic [DATA_WIDTH-1:0] seed_r, seed_n;
  logic [ADDR_WIDTH:0]   err_n;
  logic [ADDR_WIDTH-1:0] first_n;
  logic                  pass_n;
  logic                  busy_n, done_n, vld_n, wr_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  last;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_pattern;

  // Every output is a flop; the combinational block computes the value
  // each one takes after the next edge, derived from the next state so
  // that vld_o/wr_o/addr_o line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      k                <= '0;
      base_r           <= '0;
      len_r            <= '0;
      seed_r           <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      pass_o           <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      vld_o            <= 1'b0;
      wr_o             <= 1'b0;
      addr_o           <= '0;
      wdata_o          <= '0;
    end else begin
      state            <= state_n;
      k                <= k_n;
      base_r           <= base_n;
      len_r            <= len_n;
      seed_r           <= seed_n;
      err_cnt_o        <= err_n;
      first_err_addr_o <= first_n;
      pass_o           <= pass_n;
      busy_o           <= busy_n;
      done_o           <= done_n;
      vld_o            <= vld_n;
      wr_o             <= wr_n;
      addr_o           <= addr_n;
      wdata_o          <= wdata_n;
    end
  end

  // Next-state and next-output logic. While WR or RD waits on rdy_i
  // nothing that feeds addr/wdata moves, so the request stays stable.
  always_comb begin
    state_n     = state;
    k_n         = k;
    base_n      = base_r;
    len_n       = len_r;
    seed_n      = seed_r;
    err_n       = err_cnt_o;
    first_n     = first_err_addr_o;
    pass_n      = pass_o;
    last        = ({1'b0, k} == (len_r - (ADDR_WIDTH+1)'(1)));
    cur_addr    = base_r + k;
    cur_pattern = seed_r + DATA_WIDTH'(k);

    case (state)
      IDLE: begin
        if (start_i) begin
          base_n  = base_i;
          len_n   = len_i;
          seed_n  = seed_i;
          err_n   = '0;
          first_n = '0;
          pass_n  = 1'b0;
          k_n     = '0;
          state_n = (len_i == '0) ? DONE : WR;
        end
      end
      WR: begin
        if (rdy_i) begin
          if (last) begin
            k_n     = '0;
            state_n = RD;
          end else begin
            k_n = k + ADDR_WIDTH'(1);
          end
        end
      end
      RD: begin
        if (rdy_i) state_n = RCHK;
      end
      RCHK: begin
        // Read data is valid at the end of this cycle.
        if (rdata_i != cur_pattern) begin
          err_n = err_cnt_o + (ADDR_WIDTH+1)'(1);
          if (err_cnt_o == '0) first_n = cur_addr;
        end
        if (last) begin
          state_n = DONE;
        end else begin
          k_n     = k + ADDR_WIDTH'(1);
          state_n = RD;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // pass is settled on entry to DONE so it is valid alongside done_o.
    if (state_n == DONE) pass_n = (err_n == '0);

    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    vld_n   = (state_n == WR) || (state_n == RD);
    wr_n    = (state_n == WR);
    addr_n  = base_n + k_n;
    wdata_n = seed_n + DATA_WIDTH'(k_n);
  end

endmodule

// File: tb/tb_mem_pattern_master.sv
// Self-checking bench for mem_pattern_master with a behavioural
// vld/rdy memory responder. Directed table vectors plus random runs are
// checked against expectations computed from address/pattern arithmetic.
module tb_mem_pattern_master;

  localparam int AW = mem_if_pkg::DEF_ADDR_WIDTH;
  localparam int DW = mem_if_pkg::DEF_DATA_WIDTH;
  localparam int MEMSZ = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_i;
  logic [AW:0]   len_i;
  logic [DW-1:0] seed_i;
  logic          busy_o, done_o, pass_o;
  logic [AW:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic          vld_o, wr_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          rdy_i;
  logic [DW-1:0] rdata_i;

  // responder state
  logic [DW-1:0] mem [MEMSZ];
  logic          read_pending;
  logic          hold;
  logic          corrupt_en;
  logic [AW-1:0] corrupt_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] seed;
    bit            corrupt_en;
    logic [AW-1:0] corrupt_addr;
    bit            stall;
    bit            busy_start;
    int            exp_cycles;
    bit            exp_pass;
    int            exp_err;
    logic [AW-1:0] exp_first;
  } vec_t;

  vec_t tbl [7];

  mem_pattern_master dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .base_i           (base_i),
    .len_i            (len_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .vld_o            (vld_o),
    .wr_o             (wr_o),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .rdy_i            (rdy_i),
    .rdata_i          (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder: not ready in the cycle after a read accept, data returned then
  assign rdy_i = !read_pending && !hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_pending <= 1'b0;
      rdata_i      <= '0;
    end else begin
      read_pending <= 1'b0;
      if (vld_o && rdy_i) begin
        if (wr_o) begin
          mem[addr_o] <= wdata_o;
        end else begin
          rdata_i      <= mem[addr_o] ^ ((corrupt_en && addr_o == corrupt_addr) ? 16'h0001 : 16'h0000);
          read_pending <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one pattern test and checks it against the vector's expectations.
  task automatic applyStimulus(input vec_t v);
    logic [23:0]   wq[$];
    logic [AW-1:0] rq[$];
    int            cov[MEMSZ];
    int            vld_cycles, busy_cycles, stab_bad, done_cycle, seq_bad, mem_bad, cov_bad, n;
    bit            have_prev;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    int            ea, ed;

    vld_cycles = 0; busy_cycles = 0; stab_bad = 0; done_cycle = 0;
    have_prev = 0; p_wr = 0; p_addr = '0; p_wdata = '0;
    n = int'(v.len);
    corrupt_en = v.corrupt_en;
    corrupt_addr = v.corrupt_addr;

    @(negedge clk);
    base_i = v.base; len_i = v.len; seed_i = v.seed; start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3 * n + 20 && done_cycle == 0; c++) begin
      @(negedge clk);
      start_i = v.busy_start && c >= 2 && c <= 4;
      if (start_i) begin
        base_i = ~v.base; len_i = 9'd3; seed_i = ~v.seed;
      end
      hold = v.stall && c >= 2 && c <= 4;
      #1;
      if (have_prev && (!vld_o || wr_o !== p_wr || addr_o !== p_addr || wdata_o !== p_wdata))
        stab_bad++;
      have_prev = vld_o && !rdy_i;
      p_wr = wr_o; p_addr = addr_o; p_wdata = wdata_o;
      if (vld_o && rdy_i) begin
        if (wr_o) wq.push_back({addr_o, wdata_o});
        else      rq.push_back(addr_o);
      end
      if (vld_o)  vld_cycles++;
      if (busy_o) busy_cycles++;
      if (done_o) done_cycle = c;
    end
    hold = 1'b0;

    checkOutput("done_cycle", done_cycle, v.exp_cycles);
    checkOutput("pass", pass_o, v.exp_pass);
    checkOutput("err_cnt", err_cnt_o, v.exp_err);
    checkOutput("first_err_addr", first_err_addr_o, v.exp_first);
    checkOutput("busy_cycles", busy_cycles, v.exp_cycles);
    checkOutput("vld_cycles", vld_cycles, 2 * n + (v.stall ? 3 : 0));
    checkOutput("stable_req", stab_bad, 0);
    checkOutput("wr_count", wq.size(), n);
    checkOutput("rd_count", rq.size(), n);

    seq_bad = 0; mem_bad = 0; cov_bad = 0;
    foreach (cov[i]) cov[i] = 0;
    for (int kk = 0; kk < n; kk++) begin
      ea = (int'(v.base) + kk) % MEMSZ;
      ed = (int'(v.seed) + kk) % (1 << DW);
      if (kk < wq.size() && wq[kk] !== 24'(ea * 65536 + ed)) seq_bad++;
      if (kk < rq.size() && rq[kk] !== AW'(ea)) seq_bad++;
      if (mem[ea] !== DW'(ed)) mem_bad++;
    end
    foreach (wq[i]) cov[int'(wq[i][23:16])]++;
    foreach (cov[i]) if (cov[i] > 1) cov_bad++;
    checkOutput("sequence", seq_bad, 0);
    checkOutput("mem_content", mem_bad, 0);
    checkOutput("single_write", cov_bad, 0);

    // start during the DONE cycle must be ignored
    if (done_cycle != 0) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      #1;
      checkOutput("start_in_done_ignored", {vld_o, busy_o}, 2'b00);
      checkOutput("status_hold", pass_o, v.exp_pass);
    end
    start_i = 1'b0;
  endtask

  // Model for random runs: expected status from address arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err = 0;
    r.exp_first = '0;
    for (int kk = 0; kk < int'(v.len); kk++) begin
      if (v.corrupt_en && (int'(v.base) + kk) % MEMSZ == int'(v.corrupt_addr)) begin
        if (r.exp_err == 0) r.exp_first = v.corrupt_addr;
        r.exp_err++;
      end
    end
    r.exp_pass = (r.exp_err == 0);
    r.exp_cycles = 3 * int'(v.len) + 1 + (v.stall ? 3 : 0);
    return r;
  endfunction

  initial begin
    vec_t v;
    bit   seen;

    tbl[0] = '{8'h10, 9'd4,   16'h1000, 0, 8'h00, 0, 0, 13,  1, 0, 8'h00};
    tbl[1] = '{8'h33, 9'd0,   16'h0055, 0, 8'h00, 0, 0, 1,   1, 0, 8'h00};
    tbl[2] = '{8'hFE, 9'd4,   16'hFFFE, 0, 8'h00, 0, 0, 13,  1, 0, 8'h00};
    tbl[3] = '{8'h10, 9'd4,   16'h1000, 1, 8'h12, 0, 0, 13,  0, 1, 8'h12};
    tbl[4] = '{8'h10, 9'd4,   16'h1000, 0, 8'h00, 1, 0, 16,  1, 0, 8'h00};
    tbl[5] = '{8'h40, 9'd5,   16'h2222, 0, 8'h00, 0, 1, 16,  1, 0, 8'h00};
    tbl[6] = '{8'h80, 9'd256, 16'hABCD, 0, 8'h00, 0, 0, 769, 1, 0, 8'h00};

    rst_n = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; seed_i = '0;
    hold = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {vld_o, wr_o, busy_o, done_o, pass_o}, 5'b0);
    checkOutput("reset_data", {addr_o, wdata_o, err_cnt_o, first_err_addr_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(tbl[i]);
    end

    // asynchronous reset while a read is outstanding
    @(negedge clk);
    base_i = 8'h20; len_i = 9'd6; seed_i = 16'h3000; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (vld_o && !wr_o) seen = 1;
    end
    checkOutput("reached_rd", seen, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", {vld_o, wr_o, busy_o, done_o, pass_o}, 5'b0);
    checkOutput("async_rst_data", {addr_o, wdata_o, err_cnt_o, first_err_addr_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(tbl[0]);

    // random runs against the model
    for (int i = 0; i < 8; i++) begin
      v.base = AW'($urandom_range(0, MEMSZ - 1));
      v.len = (AW+1)'($urandom_range(0, 24));
      v.seed = DW'($urandom);
      v.corrupt_en = 1'($urandom_range(0, 1));
      v.corrupt_addr = v.base + AW'($urandom_range(0, 30));
      v.stall = 1'b0;
      v.busy_start = 1'($urandom_range(0, 1));
      v = model(v);
      $display("[TB] random %0d base=%0h len=%0d", i, v.base, v.len);
      applyStimulus(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
